// File: rtl/axi_stream_packet_arbiter.sv
// Packet-level round-robin arbiter feeding one header-insert datapath.
// One requester owns the payload and header paths until its last beat and single header are accepted.
//
// state    | meaning
// IDLE     | no owner; round-robin pick among payload requesters
// LOCKED   | owner's payload and header forwarded independently
// HDR_WAIT | last beat accepted, waiting only for the owner's header
module axi_stream_packet_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH),
  parameter int IDX_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        data_in,
  input  logic [NUM_REQ*DATA_BYTE_WIDTH-1:0]   keep_in,
  input  logic [NUM_REQ-1:0]                   last_in,
  output logic [NUM_REQ-1:0]                   ready_in,
  input  logic [NUM_REQ-1:0]                   valid_hdr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        data_hdr,
  input  logic [NUM_REQ*DATA_BYTE_WIDTH-1:0]   keep_hdr,
  input  logic [NUM_REQ*BYTE_CNT_WIDTH-1:0]    cnt_hdr,
  output logic [NUM_REQ-1:0]                   ready_hdr,
  output logic                                 valid_out,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [DATA_BYTE_WIDTH-1:0]           keep_out,
  output logic                                 last_out,
  input  logic                                 ready_out,
  output logic                                 valid_insert,
  output logic [DATA_WIDTH-1:0]                data_insert,
  output logic [DATA_BYTE_WIDTH-1:0]           keep_insert,
  output logic [BYTE_CNT_WIDTH-1:0]            byte_insert_cnt,
  input  logic                                 ready_insert,
  output logic [IDX_WIDTH-1:0]                 grant_idx,
  output logic                                 busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED   = 2'd1,
    HDR_WAIT = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic                 hdr_pend;
  logic                 pay_done;

  logic [DATA_WIDTH-1:0]      pay_data [NUM_REQ];
  logic [DATA_BYTE_WIDTH-1:0] pay_keep [NUM_REQ];
  logic [DATA_WIDTH-1:0]      hdr_data [NUM_REQ];
  logic [DATA_BYTE_WIDTH-1:0] hdr_keep [NUM_REQ];
  logic [BYTE_CNT_WIDTH-1:0]  hdr_cnt  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign pay_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign pay_keep[i] = keep_in[i*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
    assign hdr_data[i] = data_hdr[i*DATA_WIDTH +: DATA_WIDTH];
    assign hdr_keep[i] = keep_hdr[i*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
    assign hdr_cnt[i]  = cnt_hdr[i*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH];
  end

  // Transparent mux on the registered owner: a stable source gives stable outputs during a stall.
  assign data_out        = pay_data[grant_idx];
  assign keep_out        = pay_keep[grant_idx];
  assign last_out        = last_in[grant_idx];
  assign data_insert     = hdr_data[grant_idx];
  assign keep_insert     = hdr_keep[grant_idx];
  assign byte_insert_cnt = hdr_cnt[grant_idx];

  assign valid_out    = (state == LOCKED) && !pay_done && valid_in[grant_idx];
  assign valid_insert = (state != IDLE) && hdr_pend && valid_hdr[grant_idx];

  logic pay_hs, last_hs, hdr_hs, pay_ok, hdr_ok;
  assign pay_hs  = valid_out && ready_out;
  assign last_hs = pay_hs && last_out;
  assign hdr_hs  = valid_insert && ready_insert;
  assign pay_ok  = pay_done || last_hs;
  assign hdr_ok  = !hdr_pend || hdr_hs;

  always_comb begin
    ready_in = '0;
    if (state == LOCKED && !pay_done) ready_in[grant_idx] = ready_out;
  end

  always_comb begin
    ready_hdr = '0;
    if (state != IDLE && hdr_pend) ready_hdr[grant_idx] = ready_insert;
  end

  // Scan rr_ptr+1, rr_ptr+2, ... with wrap; the first requester found wins.
  logic                 arb_hit;
  logic [IDX_WIDTH-1:0] arb_idx;
  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : cand + IDX_WIDTH'(1);
      if (!arb_hit && valid_in[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDX_WIDTH'(NUM_REQ - 1);
      hdr_pend  <= 1'b0;
      pay_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant_idx <= arb_idx;
            hdr_pend  <= 1'b1;
            pay_done  <= 1'b0;
            state     <= LOCKED;
            busy      <= 1'b1;
          end
        end
        LOCKED: begin
          if (hdr_hs)  hdr_pend <= 1'b0;
          if (last_hs) pay_done <= 1'b1;
          if (pay_ok && hdr_ok) begin
            state  <= IDLE;
            rr_ptr <= grant_idx;
            busy   <= 1'b0;
          end else if (last_hs) begin
            state <= HDR_WAIT;
          end
        end
        HDR_WAIT: begin
          if (hdr_hs) begin
            hdr_pend <= 1'b0;
            state    <= IDLE;
            rr_ptr   <= grant_idx;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Scoreboard bench for axi_stream_packet_arbiter: per-requester sources, expected beats and headers
// queued at stimulus time and compared when the arbiter hands them downstream.
module tb_axi_stream_packet_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int IW = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic [CW-1:0] cnt;
  } hdr_t;

  logic clk, rst;
  logic [N-1:0]    valid_in, last_in, ready_in, valid_hdr, ready_hdr;
  logic [N*DW-1:0] data_in, data_hdr;
  logic [N*BW-1:0] keep_in, keep_hdr;
  logic [N*CW-1:0] cnt_hdr;
  logic            valid_out, last_out, ready_out, valid_insert, ready_insert, busy;
  logic [DW-1:0]   data_out, data_insert;
  logic [BW-1:0]   keep_out, keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic [IW-1:0]   grant_idx;

  logic [DW-1:0] din  [N];
  logic [BW-1:0] kin  [N];
  logic [DW-1:0] dhdr [N];
  logic [BW-1:0] khdr [N];
  logic [CW-1:0] chdr [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign data_in[g*DW +: DW]  = din[g];
    assign keep_in[g*BW +: BW]  = kin[g];
    assign data_hdr[g*DW +: DW] = dhdr[g];
    assign keep_hdr[g*BW +: BW] = khdr[g];
    assign cnt_hdr[g*CW +: CW]  = chdr[g];
  end

  axi_stream_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .cnt_hdr(cnt_hdr), .ready_hdr(ready_hdr),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .grant_idx(grant_idx), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  beat_t src_pay [N][$];
  beat_t exp_pay [N][$];
  hdr_t  src_hdr [N][$];
  hdr_t  exp_hdr [N][$];
  int    exp_grant [$];

  int checks, errors;
  int beats_seen, hdrs_seen, pkts_seen, stalls_seen, cyc;
  int owner;
  bit pkt_open, last_seen, stall_prev;
  logic [DW-1:0] stall_data;
  int ro_mode;
  bit ri_en;
  logic [N-1:0] pay_en;

  task automatic push_pkt(input int r, input int nb, input logic [DW-1:0] base,
                          input logic [DW-1:0] hdr, input logic [CW-1:0] cnt);
    beat_t b;
    hdr_t  h;
    for (int j = 0; j < nb; j++) begin
      b.data = base + DW'(j);
      b.keep = (j == nb - 1) ? 4'h7 : 4'hF;
      b.last = (j == nb - 1);
      src_pay[r].push_back(b);
      exp_pay[r].push_back(b);
    end
    h.data = hdr;
    h.keep = 4'hF;
    h.cnt  = cnt;
    src_hdr[r].push_back(h);
    exp_hdr[r].push_back(h);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++)
      if (src_pay[i].size() != 0 || src_hdr[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      src_pay[i].delete();
      exp_pay[i].delete();
      src_hdr[i].delete();
      exp_hdr[i].delete();
    end
    exp_grant.delete();
    pkt_open   = 1'b0;
    stall_prev = 1'b0;
  endtask

  // One clock: drive sources at posedge+1, observe and score at negedge.
  task automatic step();
    int g;
    beat_t e;
    hdr_t eh;
    logic [N-1:0] allow;
    cyc++;
    for (int i = 0; i < N; i++) begin
      valid_in[i] = pay_en[i] && (src_pay[i].size() != 0);
      if (src_pay[i].size() != 0) begin
        din[i] = src_pay[i][0].data; kin[i] = src_pay[i][0].keep; last_in[i] = src_pay[i][0].last;
      end else begin
        din[i] = '0; kin[i] = '0; last_in[i] = 1'b0;
      end
      valid_hdr[i] = (src_hdr[i].size() != 0);
      if (src_hdr[i].size() != 0) begin
        dhdr[i] = src_hdr[i][0].data; khdr[i] = src_hdr[i][0].keep; chdr[i] = src_hdr[i][0].cnt;
      end else begin
        dhdr[i] = '0; khdr[i] = '0; chdr[i] = '0;
      end
    end
    ready_out    = (ro_mode == 0) ? 1'b1 : cyc[0];
    ready_insert = ri_en;
    @(negedge clk);
    if (!rst) begin
      g = int'(grant_idx);
      allow = '0;
      if (busy) allow[grant_idx] = 1'b1;
      checks++;
      if ((ready_in & ~allow) != '0 || (ready_hdr & ~allow) != '0 || (!busy && (valid_out || valid_insert))) begin
        errors++;
        $display("FAIL isolation: ready_in=%b ready_hdr=%b valid_out=%b valid_insert=%b busy=%b grant=%0d",
                 ready_in, ready_hdr, valid_out, valid_insert, busy, g);
      end
      if (stall_prev) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== stall_data) begin
          errors++;
          $display("FAIL stall_stable: valid_out=%b data_out=%h, required 1 and %h", valid_out, data_out, stall_data);
        end
      end
      stall_prev = valid_out && !ready_out;
      stall_data = data_out;
      if (stall_prev) stalls_seen++;
      if (valid_out && ready_out) begin
        checks++;
        if (exp_pay[g].size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: requester %0d data %h with nothing expected", g, data_out);
        end else begin
          e = exp_pay[g].pop_front();
          if ({data_out, keep_out, last_out} !== {e.data, e.keep, e.last}) begin
            errors++;
            $display("FAIL beat: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                     data_out, keep_out, last_out, e.data, e.keep, e.last);
          end
          checks++;
          if (!pkt_open) begin
            if (exp_grant.size() == 0 || g != exp_grant[0]) begin
              errors++;
              $display("FAIL grant_order: got %0d, want %0d", g, (exp_grant.size() != 0) ? exp_grant[0] : -1);
            end
            if (exp_grant.size() != 0) void'(exp_grant.pop_front());
            pkt_open = 1'b1;
            owner = g;
          end else if (g != owner) begin
            errors++;
            $display("FAIL interleave: beat from %0d inside packet of %0d", g, owner);
          end
          beats_seen++;
          if (e.last) begin
            pkt_open  = 1'b0;
            last_seen = 1'b1;
            pkts_seen++;
          end
        end
      end
      if (valid_insert && ready_insert) begin
        checks++;
        if (exp_hdr[g].size() == 0) begin
          errors++;
          $display("FAIL unexpected_hdr: requester %0d header %h with nothing expected", g, data_insert);
        end else begin
          eh = exp_hdr[g].pop_front();
          if ({data_insert, keep_insert, byte_insert_cnt} !== {eh.data, eh.keep, eh.cnt}) begin
            errors++;
            $display("FAIL header: got %h/%h/%0d, want %h/%h/%0d",
                     data_insert, keep_insert, byte_insert_cnt, eh.data, eh.keep, eh.cnt);
          end
        end
        hdrs_seen++;
      end
      for (int i = 0; i < N; i++) begin
        if (valid_in[i] && ready_in[i] && src_pay[i].size() != 0) void'(src_pay[i].pop_front());
        if (valid_hdr[i] && ready_hdr[i] && src_hdr[i].size() != 0) void'(src_hdr[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && busy == 1'b0) && n < budget);
    checks++;
    if (!(all_empty() && busy == 1'b0)) begin
      errors++;
      $display("FAIL drain_timeout: still busy=%b after %0d cycles", busy, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    flush();
  endtask

  task automatic test_reset();
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant_idx !== '0 || valid_out !== 1'b0 || valid_insert !== 1'b0 ||
        ready_in !== '0 || ready_hdr !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b grant=%0d valid_out=%b valid_insert=%b ready_in=%b ready_hdr=%b, want all 0",
               busy, grant_idx, valid_out, valid_insert, ready_in, ready_hdr);
    end
  endtask

  task automatic test_single();
    int b0, h0;
    b0 = beats_seen; h0 = hdrs_seen;
    push_pkt(0, 4, 32'h1, 32'hAABBCCDD, 2'd3);
    exp_grant.push_back(0);
    step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b0 || beats_seen != b0) begin
      errors++;
      $display("FAIL single_arb: busy=%b grant=%0d beats=%0d, want 1 0 0", busy, grant_idx, beats_seen - b0);
    end
    last_seen = 1'b0;
    for (int k = 0; k < 20 && !last_seen; k++) step();
    checks++;
    if (busy !== 1'b0 || beats_seen - b0 != 4 || hdrs_seen - h0 != 1) begin
      errors++;
      $display("FAIL single_done: busy=%b beats=%0d hdrs=%0d, want 0 4 1", busy, beats_seen - b0, hdrs_seen - h0);
    end
  endtask

  task automatic test_alternate();
    int p0, n;
    do_reset();
    p0 = pkts_seen;
    push_pkt(0, 3, 32'h100, 32'h0A0A0A0A, 2'd1);
    push_pkt(1, 3, 32'h200, 32'h1B1B1B1B, 2'd2);
    push_pkt(0, 3, 32'h300, 32'h2C2C2C2C, 2'd3);
    push_pkt(1, 3, 32'h400, 32'h3D3D3D3D, 2'd0);
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    drain(100, n);
    checks++;
    if (pkts_seen - p0 != 4 || exp_grant.size() != 0) begin
      errors++;
      $display("FAIL alternate: packets=%0d pending_grants=%0d, want 4 0", pkts_seen - p0, exp_grant.size());
    end
  endtask

  task automatic test_hdr_wait();
    int h0, n;
    ri_en = 1'b0;
    push_pkt(1, 3, 32'h500, 32'h11223344, 2'd2);
    exp_grant.push_back(1);
    last_seen = 1'b0;
    for (int k = 0; k < 20 && !last_seen; k++) step();
    checks++;
    if (!last_seen || busy !== 1'b1 || valid_out !== 1'b0 || ready_in !== '0 || valid_insert !== 1'b1 || grant_idx !== 1'b1) begin
      errors++;
      $display("FAIL hdr_wait_enter: last=%b busy=%b valid_out=%b ready_in=%b valid_insert=%b grant=%0d",
               last_seen, busy, valid_out, ready_in, valid_insert, grant_idx);
    end
    push_pkt(1, 2, 32'h600, 32'h55667788, 2'd1);
    exp_grant.push_back(1);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (busy !== 1'b1 || valid_out !== 1'b0 || ready_in !== '0) begin
        errors++;
        $display("FAIL hdr_wait_hold: busy=%b valid_out=%b ready_in=%b, want 1 0 00", busy, valid_out, ready_in);
      end
    end
    ri_en = 1'b1;
    h0 = hdrs_seen;
    step();
    checks++;
    if (busy !== 1'b0 || hdrs_seen - h0 != 1) begin
      errors++;
      $display("FAIL hdr_wait_release: busy=%b hdrs=%0d, want 0 1", busy, hdrs_seen - h0);
    end
    drain(50, n);
  endtask

  task automatic test_stall();
    int b0, s0, n;
    ro_mode = 1;
    b0 = beats_seen; s0 = stalls_seen;
    push_pkt(0, 6, 32'h700, 32'h99AA99AA, 2'd3);
    exp_grant.push_back(0);
    drain(60, n);
    ro_mode = 0;
    checks++;
    if (beats_seen - b0 != 6 || stalls_seen == s0) begin
      errors++;
      $display("FAIL stall: beats=%0d stalls=%0d, want 6 and >0", beats_seen - b0, stalls_seen - s0);
    end
  endtask

  task automatic test_same_cycle();
    int h0;
    push_pkt(1, 1, 32'h800, 32'hC0C0C0C0, 2'd1);
    push_pkt(0, 1, 32'h900, 32'hD0D0D0D0, 2'd2);
    exp_grant.push_back(1); exp_grant.push_back(0);
    step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b1) begin
      errors++;
      $display("FAIL same_arb1: busy=%b grant=%0d, want 1 1", busy, grant_idx);
    end
    h0 = hdrs_seen; last_seen = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || !last_seen || hdrs_seen - h0 != 1) begin
      errors++;
      $display("FAIL same_release: busy=%b last=%b hdrs=%0d, want 0 1 1", busy, last_seen, hdrs_seen - h0);
    end
    step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b0) begin
      errors++;
      $display("FAIL same_arb2: busy=%b grant=%0d, want 1 0", busy, grant_idx);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL same_release2: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int p0, n;
    p0 = pkts_seen;
    push_pkt(0, 2, 32'hA00, 32'hE1E1E1E1, 2'd0);
    push_pkt(0, 2, 32'hB00, 32'hE2E2E2E2, 2'd1);
    exp_grant.push_back(0); exp_grant.push_back(0);
    drain(40, n);
    checks++;
    if (n != 6 || pkts_seen - p0 != 2) begin
      errors++;
      $display("FAIL back_to_back: cycles=%0d packets=%0d, want 6 2", n, pkts_seen - p0);
    end
  endtask

  task automatic test_gap();
    int p0, n;
    p0 = pkts_seen;
    push_pkt(0, 4, 32'hC00, 32'hF0F0F0F0, 2'd2);
    exp_grant.push_back(0);
    step();
    push_pkt(1, 2, 32'hD00, 32'hF1F1F1F1, 2'd3);
    exp_grant.push_back(1);
    step();
    pay_en[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (busy !== 1'b1 || grant_idx !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold: busy=%b grant=%0d valid_out=%b, want 1 0 0", busy, grant_idx, valid_out);
      end
    end
    pay_en[0] = 1'b1;
    drain(50, n);
    checks++;
    if (pkts_seen - p0 != 2) begin
      errors++;
      $display("FAIL gap: packets=%0d, want 2", pkts_seen - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0, n;
    push_pkt(1, 4, 32'hE00, 32'h13579BDF, 2'd1);
    exp_grant.push_back(1);
    step();
    checks++;
    if (grant_idx !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_grant: grant=%0d, want 1", grant_idx);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant_idx !== '0 || valid_out !== 1'b0 || valid_insert !== 1'b0 ||
        ready_in !== '0 || ready_hdr !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: busy=%b grant=%0d valid_out=%b valid_insert=%b ready_in=%b ready_hdr=%b, want all 0",
               busy, grant_idx, valid_out, valid_insert, ready_in, ready_hdr);
    end
    flush();
    p0 = pkts_seen;
    push_pkt(1, 1, 32'hF00, 32'h2468ACE0, 2'd2);
    push_pkt(0, 1, 32'hF10, 32'h3579BDF1, 2'd3);
    exp_grant.push_back(0); exp_grant.push_back(1);
    drain(40, n);
    checks++;
    if (pkts_seen - p0 != 2 || exp_grant.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_rearb: packets=%0d pending_grants=%0d, want 2 0", pkts_seen - p0, exp_grant.size());
    end
  endtask

  initial begin
    checks = 0; errors = 0; beats_seen = 0; hdrs_seen = 0; pkts_seen = 0; stalls_seen = 0; cyc = 0;
    owner = 0; pkt_open = 1'b0; last_seen = 1'b0; stall_prev = 1'b0; stall_data = '0;
    ro_mode = 0; ri_en = 1'b1; pay_en = '1;
    rst = 1'b1;
    valid_in = '0; last_in = '0; valid_hdr = '0; ready_out = 1'b0; ready_insert = 1'b0;
    for (int i = 0; i < N; i++) begin
      din[i] = '0; kin[i] = '0; dhdr[i] = '0; khdr[i] = '0; chdr[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_hdr_wait();
    test_stall();
    test_same_cycle();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_pay[i].size() != 0 || exp_hdr[i].size() != 0) begin
        errors++;
        $display("FAIL leftover: requester %0d beats=%0d headers=%0d, want 0 0", i, exp_pay[i].size(), exp_hdr[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
